// File: rtl/sat_ctr_pkg.sv
// -----------------------------------------------------------------------------
// sat_ctr_pkg
//   Shared constants and types for the saturating/wrapping counter.
//
//   Contents:
//     DIR_UP / DIR_DOWN     : encodings of the dir input
//     WRAP_SAT / WRAP_ROLL  : values of the WRAP parameter
//     next_sel_e            : which source feeds the next count value
//     max_count()           : largest value representable in a given width
//
//   Build option (used by sat_ctr):
//     SAT_CTR_STICKY_ERR_EN : registered, sticky err flag when defined
// -----------------------------------------------------------------------------
package sat_ctr_pkg;

   // Direction encoding on the dir input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Behaviour at the count bounds.
   localparam int WRAP_SAT  = 0;   // hold at the bound
   localparam int WRAP_ROLL = 1;   // roll over to the opposite bound

   // Source of the next count value, in decreasing priority.
   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,   // keep the current count
      SEL_CLEAR = 3'd1,   // synchronous clear
      SEL_LOAD  = 3'd2,   // legal load value
      SEL_FIX   = 3'd3,   // recover from an out-of-range count
      SEL_STEP  = 3'd4    // increment / decrement / wrap / saturate
   } next_sel_e;

   // Largest unsigned value that fits in 'width' bits.
   function automatic int max_count(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/dff.sv
// -----------------------------------------------------------------------------
// dff
//   Single-bit storage cell with asynchronous active-high reset to 0.
//
//   Ports:
//     clk  : clock, captures d_i on the rising edge
//     rst  : asynchronous active-high reset, forces q_o to 0
//     d_i  : data input
//     q_o  : registered output
// -----------------------------------------------------------------------------
module dff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/sat_ctr.sv
// -----------------------------------------------------------------------------
// sat_ctr
//   Up/down counter over the range 0..MAX_VAL that either saturates at the
//   bounds (WRAP=0) or rolls over (WRAP=1). Supports synchronous clear and
//   load, and flags out-of-range loads and out-of-range counts on err.
//
//   Parameters:
//     WIDTH   : count width in bits
//     MAX_VAL : terminal count, 1 .. 2**WIDTH-1
//     WRAP    : WRAP_SAT (0) or WRAP_ROLL (1)
//
//   Ports:
//     clk      : clock, all state changes on the rising edge
//     rst      : asynchronous active-high reset (count and err to 0)
//     ctr_rst  : synchronous clear, highest priority
//     en       : count enable
//     dir      : 1 = count up, 0 = count down
//     load     : synchronous load strobe
//     load_val : value to load, ignored when above MAX_VAL
//     out      : current count, straight from the state register
//     sat      : count sits at the bound of the current direction
//     err      : bad load value or out-of-range count
//
//   Build option:
//     SAT_CTR_STICKY_ERR_EN defined   : err is registered and stays high from
//                                       the edge after an error condition
//                                       until rst or ctr_rst.
//     SAT_CTR_STICKY_ERR_EN undefined : err is combinational and only high
//                                       while the error condition holds.
// -----------------------------------------------------------------------------
module sat_ctr
   import sat_ctr_pkg::*;
#(
   parameter int WIDTH   = 3,
   parameter int MAX_VAL = 5,
   parameter int WRAP    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctr_rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             sat,
   output logic             err
);

   // Reject terminal counts that are zero or do not fit in WIDTH bits.
   if (MAX_VAL < 1 || MAX_VAL > max_count(WIDTH)) begin : g_bad_max_val
      $error("sat_ctr: MAX_VAL must lie in 1 .. 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ZERO_W  = '0;
   localparam bit               WRAP_EN = (WRAP == WRAP_ROLL);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] step_val;
   logic             illegal_cnt;
   logic             load_ok;
   logic             load_bad;
   logic             err_cond;
   next_sel_e        sel;

   // ---------------------------------------------------------------------------
   // Decode of the current state and the control inputs.
   // ---------------------------------------------------------------------------
   always_comb begin
      illegal_cnt = (count_q > MAX_W);
      load_ok     = load && (load_val <= MAX_W);
      load_bad    = load && !load_ok;

      // A rejected load blocks counting for that cycle, but an out-of-range
      // count is still pulled back to zero underneath it.
      sel = SEL_HOLD;
      if (ctr_rst) begin
         sel = SEL_CLEAR;
      end else if (load_ok) begin
         sel = SEL_LOAD;
      end else if (illegal_cnt) begin
         sel = SEL_FIX;
      end else if (load_bad) begin
         sel = SEL_HOLD;
      end else if (en) begin
         sel = SEL_STEP;
      end

      // The load is not evaluated at all while ctr_rst is asserted, so a bad
      // load_val only counts as an error when ctr_rst is low.
      err_cond = (load_bad && !ctr_rst) || illegal_cnt;
   end

   // ---------------------------------------------------------------------------
   // One count step in the requested direction. The bounds are compared
   // explicitly, so MAX_VAL = 2**WIDTH-1 saturates or wraps exactly like any
   // other terminal count instead of relying on WIDTH-bit overflow.
   // ---------------------------------------------------------------------------
   always_comb begin
      step_val = count_q;
      if (dir == DIR_UP) begin
         if (count_q == MAX_W) begin
            step_val = WRAP_EN ? ZERO_W : MAX_W;
         end else begin
            step_val = count_q + 1'b1;
         end
      end else begin
         if (count_q == ZERO_W) begin
            step_val = WRAP_EN ? MAX_W : ZERO_W;
         end else begin
            step_val = count_q - 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-count mux.
   // ---------------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      case (sel)
         SEL_CLEAR: count_d = ZERO_W;
         SEL_LOAD:  count_d = load_val;
         SEL_FIX:   count_d = ZERO_W;
         SEL_STEP:  count_d = step_val;
         default:   count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Count state register, one storage cell per bit.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff u_dff (
         .clk (clk),
         .rst (rst),
         .d_i (count_d[i]),
         .q_o (count_q[i])
      );
   end

   assign out = count_q;

   // sat looks only at count and dir, so it is valid whether or not en is set.
   assign sat = (dir == DIR_UP) ? (count_q == MAX_W) : (count_q == ZERO_W);

   // ---------------------------------------------------------------------------
   // Error flag.
   // ---------------------------------------------------------------------------
`ifdef SAT_CTR_STICKY_ERR_EN
   logic err_q;
   logic err_d;

   // ctr_rst wins over a simultaneous error so that a clear always clears.
   always_comb begin
      err_d = err_q | err_cond;
      if (ctr_rst) begin
         err_d = 1'b0;
      end
   end

   dff u_err_dff (
      .clk (clk),
      .rst (rst),
      .d_i (err_d),
      .q_o (err_q)
   );

   assign err = err_q;
`else
   assign err = err_cond;
`endif

endmodule

// File: tb/tb_sat_ctr.sv
// -----------------------------------------------------------------------------
// tb_sat_ctr
//   Directed bench for sat_ctr with WIDTH=3, MAX_VAL=5. One instance
//   saturates (WRAP=0), a second one wraps (WRAP=1); both see the same
//   stimulus. Inputs change 1 time unit after a rising edge; outputs are
//   sampled 1 time unit after the edge or, for combinational checks, 1 time
//   unit after the inputs change.
// -----------------------------------------------------------------------------
module tb_sat_ctr;

   localparam int WIDTH   = 3;
   localparam int MAX_VAL = 5;

   logic             clk;
   logic             rst;
   logic             ctr_rst;
   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out_s;
   logic             sat_s;
   logic             err_s;
   logic [WIDTH-1:0] out_w;
   logic             sat_w;
   logic             err_w;

   int n_cmp;
   int n_bad;

   sat_ctr #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .WRAP(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .ctr_rst  (ctr_rst),
      .en       (en),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .out      (out_s),
      .sat      (sat_s),
      .err      (err_s)
   );

   sat_ctr #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .WRAP(1)) dut_w (
      .clk      (clk),
      .rst      (rst),
      .ctr_rst  (ctr_rst),
      .en       (en),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .out      (out_w),
      .sat      (sat_w),
      .err      (err_w)
   );

   // ---------------------------------------------------------------------------
   // Clock and watchdog
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Driver tasks and checker
   // ---------------------------------------------------------------------------
   task automatic drive(input logic cr, input logic ld, input logic [WIDTH-1:0] lv,
                        input logic e, input logic d);
      ctr_rst  = cr;
      load     = ld;
      load_val = lv;
      en       = e;
      dir      = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Vector table: inputs for one edge, expected err before the edge, expected
   // out/sat after it. Walked from count 0 on the saturating instance.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic             cr;
      logic             ld;
      logic [WIDTH-1:0] lv;
      logic             e;
      logic             d;
      logic [WIDTH-1:0] exp_out;
      logic             exp_sat;
      logic             exp_err;         // combinational err build
      logic             exp_err_sticky;  // sticky err build
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs[NVEC];

   logic [WIDTH-1:0] exp_up7[7];
   logic [WIDTH-1:0] exp_wrap3[3];
   logic             exp_wsat3[3];

   logic exp_e;

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      n_cmp = 0;
      n_bad = 0;

      //            cr    ld    lv    en    dir   out   sat   err   err_st
      vecs[0]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};

      exp_up7   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
      exp_wrap3 = '{3'd0, 3'd5, 3'd4};
      exp_wsat3 = '{1'b1, 1'b0, 1'b0};

      // Reset state
      rst = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      #2;
      check("reset_out", 8'(out_s), 8'd0);
      check("reset_err", 8'(err_s), 8'd0);
      check("reset_out_wrap", 8'(out_w), 8'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("post_reset_out", 8'(out_s), 8'd0);

      // Table-driven vectors
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].cr, vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].d);
         #1;
`ifdef SAT_CTR_STICKY_ERR_EN
         check($sformatf("vec%0d_err", i), 8'(err_s), 8'(vecs[i].exp_err_sticky));
`else
         check($sformatf("vec%0d_err", i), 8'(err_s), 8'(vecs[i].exp_err));
`endif
         step();
         check($sformatf("vec%0d_out", i), 8'(out_s), 8'(vecs[i].exp_out));
         check($sformatf("vec%0d_sat", i), 8'(sat_s), 8'(vecs[i].exp_sat));
      end

      // Count up from 0 for 7 edges: saturates at 5
      drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      step();
      check("up7_start", 8'(out_s), 8'd0);
      drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step();
         check($sformatf("up7_out%0d", i), 8'(out_s), 8'(exp_up7[i]));
         check($sformatf("up7_sat%0d", i), 8'(sat_s), (exp_up7[i] == 3'd5) ? 8'd1 : 8'd0);
      end

      // Wrapping instance: count down from 1 for 3 edges -> 0, 5, 4
      drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
      step();
      check("wrap_start", 8'(out_w), 8'd1);
      drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("wrap_out%0d", i), 8'(out_w), 8'(exp_wrap3[i]));
         check($sformatf("wrap_sat%0d", i), 8'(sat_w), 8'(exp_wsat3[i]));
      end

      // Out-of-range load at count 2
      drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
      step();
      check("badload_start", 8'(out_s), 8'd2);
      drive(1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
      #1;
`ifdef SAT_CTR_STICKY_ERR_EN
      exp_e = 1'b0;
`else
      exp_e = 1'b1;
`endif
      check("badload_err_same", 8'(err_s), 8'(exp_e));
      step();
      check("badload_out", 8'(out_s), 8'd2);
      drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      #1;
`ifdef SAT_CTR_STICKY_ERR_EN
      exp_e = 1'b1;
`else
      exp_e = 1'b0;
`endif
      check("badload_err_next", 8'(err_s), 8'(exp_e));
      step();
      check("badload_err_later", 8'(err_s), 8'(exp_e));
      drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      step();
      check("badload_clr_err", 8'(err_s), 8'd0);
      check("badload_clr_out", 8'(out_s), 8'd0);

      // ctr_rst beats load and en
      drive(1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
      step();
      check("prio_start", 8'(out_s), 8'd3);
      drive(1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
      step();
      check("prio_out", 8'(out_s), 8'd0);

      // Asynchronous reset mid-count with a pending enable
      drive(1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
      step();
      check("arst_start", 8'(out_s), 8'd3);
      drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_now", 8'(out_s), 8'd0);
      check("arst_err_now", 8'(err_s), 8'd0);
      step();
      check("arst_hold_out", 8'(out_s), 8'd0);
      rst = 1'b0;
      #1;
      check("arst_release_out", 8'(out_s), 8'd0);
      step();
      check("arst_first_count", 8'(out_s), 8'd1);

      // Illegal state 7 recovers to 0 after one edge
      drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      force dut.g_bit[0].u_dff.q_q = 1'b1;
      force dut.g_bit[1].u_dff.q_q = 1'b1;
      force dut.g_bit[2].u_dff.q_q = 1'b1;
      #1;
      release dut.g_bit[0].u_dff.q_q;
      release dut.g_bit[1].u_dff.q_q;
      release dut.g_bit[2].u_dff.q_q;
      #1;
      check("ill_out", 8'(out_s), 8'd7);
`ifdef SAT_CTR_STICKY_ERR_EN
      exp_e = 1'b0;
`else
      exp_e = 1'b1;
`endif
      check("ill_err", 8'(err_s), 8'(exp_e));
      check("ill_sat", 8'(sat_s), 8'd0);
      step();
      check("ill_fix_out", 8'(out_s), 8'd0);
`ifdef SAT_CTR_STICKY_ERR_EN
      exp_e = 1'b1;
`else
      exp_e = 1'b0;
`endif
      check("ill_fix_err", 8'(err_s), 8'(exp_e));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
